// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding, default geometry/timing and helpers for the SRAM
// pulse-interface initiator.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF    = 7;
  localparam int DATA_W_DEF    = 32;
  localparam int SETUP_CYC_DEF = 1;
  localparam int PULSE_CYC_DEF = 2;
  localparam int HOLD_CYC_DEF  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_RESP
  } sram_ctrl_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter that times the SETUP, PULSE and HOLD phases;
// zero marks the last cycle of the current phase.
module sram_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-outstanding initiator for the SRAM macro pulse interface: setup,
// timed read/write pulse, hold, then a registered response handshake.
//
// state    | meaning
// ST_IDLE  | req_ready high, waiting for a request
// ST_SETUP | buses driven, pulses low, counting setup cycles
// ST_PULSE | read or write pulse high; last cycle captures data/err
// ST_HOLD  | pulses low, buses still held
// ST_RESP  | rsp_valid high until rsp_ready
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   sram_addr_sel,
  output logic [DATA_W/8-1:0] sram_byte_sel,
  output logic [DATA_W-1:0]   sram_datain,
  output logic                sram_read_pulse,
  output logic                sram_write_pulse,
  input  logic [DATA_W-1:0]   sram_dataout,
  input  logic                sram_complete
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  sram_ctrl_state_e state, state_nxt;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [BE_W-1:0]   be_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] be_mask;
  logic              err_d;
  logic              rd_pulse_d, wr_pulse_d;
  logic              req_ready_d, rsp_valid_d;
  logic              accept;
  logic              timer_load;
  logic [CNT_W-1:0]  timer_val;
  logic              timer_zero;

  assign accept = (state == ST_IDLE) && req_valid && req_ready;

  sram_phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // State plus every output is registered; reset drops the pulses at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      we_q             <= 1'b0;
      sram_addr_sel    <= '0;
      sram_byte_sel    <= '0;
      sram_datain      <= '0;
      sram_read_pulse  <= 1'b0;
      sram_write_pulse <= 1'b0;
      rsp_rdata        <= '0;
      rsp_err          <= 1'b0;
      rsp_valid        <= 1'b0;
      req_ready        <= 1'b0;
    end else begin
      state            <= state_nxt;
      we_q             <= we_d;
      sram_addr_sel    <= addr_d;
      sram_byte_sel    <= be_d;
      sram_datain      <= wdata_d;
      sram_read_pulse  <= rd_pulse_d;
      sram_write_pulse <= wr_pulse_d;
      rsp_rdata        <= rdata_d;
      rsp_err          <= err_d;
      rsp_valid        <= rsp_valid_d;
      req_ready        <= req_ready_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = (req_be == '0) ? ST_RESP : ST_SETUP;
      ST_SETUP: if (timer_zero) state_nxt = ST_PULSE;
      ST_PULSE: if (timer_zero) state_nxt = ST_HOLD;
      ST_HOLD:  if (timer_zero) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      be_mask[i*8 +: 8] = {8{sram_byte_sel[i]}};
    end
  end

  always_comb begin
    we_d       = we_q;
    addr_d     = sram_addr_sel;
    be_d       = sram_byte_sel;
    wdata_d    = sram_datain;
    rdata_d    = rsp_rdata;
    err_d      = rsp_err;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          we_d       = req_we;
          addr_d     = req_addr;
          be_d       = req_be;
          wdata_d    = req_wdata;
          rdata_d    = '0;
          err_d      = 1'b0;
          timer_load = 1'b1;
          timer_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (timer_zero) begin
          timer_load = 1'b1;
          timer_val  = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (timer_zero) begin
          timer_load = 1'b1;
          timer_val  = HOLD_LD;
          if (!we_q) rdata_d = sram_dataout & be_mask;
          err_d = ~sram_complete;
        end
      end
      default: ;
    endcase
    rd_pulse_d  = (state_nxt == ST_PULSE) && !we_d;
    wr_pulse_d  = (state_nxt == ST_PULSE) && we_d;
    req_ready_d = (state_nxt == ST_IDLE);
    rsp_valid_d = (state_nxt == ST_RESP);
  end

endmodule
